// File: rtl/ascon_perm_round_seq.sv
// Iterative ASCON permutation: two rounds per clock over a 320-bit state register,
// with round count selected at start (12, 8 or 6 rounds) and a one-cycle done pulse.
module ascon_perm_round_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   rounds_sel,
  input  logic [319:0] state_in,
  output logic [319:0] state_out,
  output logic [2:0]   loop_num,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         st, st_n;
  logic [319:0] state_q, state_n;
  logic [2:0]   loop_q, loop_n;
  logic         done_q, done_n;
  logic [319:0] even_p0, odd_p1;

  function automatic logic [63:0] ror64(input logic [63:0] v, input logic [6:0] n);
    return (v >> n) | (v << (7'd64 - n));
  endfunction

  function automatic logic [7:0] even_const(input logic [2:0] k);
    case (k)
      3'd0:    return 8'hf0;
      3'd1:    return 8'hd2;
      3'd2:    return 8'hb4;
      3'd3:    return 8'h96;
      3'd4:    return 8'h78;
      3'd5:    return 8'h5a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] odd_const(input logic [2:0] k);
    case (k)
      3'd0:    return 8'he1;
      3'd1:    return 8'hc3;
      3'd2:    return 8'ha5;
      3'd3:    return 8'h87;
      3'd4:    return 8'h69;
      3'd5:    return 8'h4b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] rc);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'd0, rc};
    x3 = s[127:64];
    x4 = s[63:0];
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror64(x0, 7'd19) ^ ror64(x0, 7'd28);
    x1 = x1 ^ ror64(x1, 7'd61) ^ ror64(x1, 7'd39);
    x2 = x2 ^ ror64(x2, 7'd1)  ^ ror64(x2, 7'd6);
    x3 = x3 ^ ror64(x3, 7'd10) ^ ror64(x3, 7'd17);
    x4 = x4 ^ ror64(x4, 7'd7)  ^ ror64(x4, 7'd41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [2:0] first_loop(input logic [1:0] sel);
    case (sel)
      2'b01:   return 3'd2;
      2'b10:   return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  // even-constant round, then odd-constant round, both in one cycle
  assign even_p0 = ascon_round(state_q, even_const(loop_q));
  assign odd_p1  = ascon_round(even_p0, odd_const(loop_q));

  always_comb begin
    st_n    = st;
    state_n = state_q;
    loop_n  = loop_q;
    done_n  = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          state_n = state_in;
          loop_n  = first_loop(rounds_sel);
          st_n    = RUN;
        end
      end
      RUN: begin
        state_n = odd_p1;
        if (loop_q == 3'd5) begin
          loop_n = 3'd0;
          done_n = 1'b1;
          st_n   = IDLE;
        end else begin
          loop_n = loop_q + 3'd1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      state_q <= '0;
      loop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      st      <= st_n;
      state_q <= state_n;
      loop_q  <= loop_n;
      done_q  <= done_n;
    end
  end

  assign state_out = state_q;
  assign loop_num  = loop_q;
  assign busy      = (st == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_ascon_perm_round_seq.sv
// Bench for ascon_perm_round_seq: table of permutations checked against a
// column-wise S-box reference model, plus handshake and reset sequences.
module tb_ascon_perm_round_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   rounds_sel;
  logic [319:0] state_in;
  logic [319:0] state_out;
  logic [2:0]   loop_num;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_fail = 0;

  ascon_perm_round_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rounds_sel(rounds_sel),
    .state_in  (state_in),
    .state_out (state_out),
    .loop_num  (loop_num),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  typedef struct {
    logic [319:0] s;
    logic [1:0]   sel;
    int           n;
    int           first;
    logic [319:0] exp;
  } vec_t;

  vec_t vt[6];

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  // Reference: rounds first..first+n-1 of the 12-round schedule, constant ((15-r)<<4)|r
  function automatic logic [319:0] model_rounds(input logic [319:0] s, input int first, input int n);
    logic [63:0] x[5];
    logic [63:0] y[5];
    logic [4:0]  col, sb;
    int          rot[5][2];
    rot = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int r = first; r < first + n; r++) begin
      x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        sb  = SBOX[col];
        for (int i = 0; i < 5; i++) y[i][b] = sb[4 - i];
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], rot[i][0]) ^ rotr(y[i], rot[i][1]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic vec_t mk(input logic [319:0] s, input logic [1:0] sel);
    vec_t v;
    v.s   = s;
    v.sel = sel;
    v.n   = (sel == 2'b01) ? 4 : (sel == 2'b10) ? 3 : 6;
    v.first = (sel == 2'b01) ? 2 : (sel == 2'b10) ? 3 : 0;
    v.exp = model_rounds(s, 12 - 2 * v.n, 2 * v.n);
    return v;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic [319:0] s, input logic [1:0] sel);
    @(negedge clk);
    state_in   = s;
    rounds_sel = sel;
    start      = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int           cyc;
    logic [319:0] hold;
    drive_start(v.s, v.sel);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 320'(busy), 320'(1));
    chk({tag, "_load"}, state_out, v.s);
    cyc = 0;
    while (busy && cyc < 20) begin
      chk({tag, "_loop_num"}, 320'(loop_num), 320'(v.first + cyc));
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_run_cycles"}, 320'(cyc), 320'(v.n));
    chk({tag, "_done"}, 320'(done), 320'(1));
    chk({tag, "_result"}, state_out, v.exp);
    hold = state_out;
    @(posedge clk); #1;
    chk({tag, "_done_cleared"}, 320'(done), 320'(0));
    chk({tag, "_result_held"}, state_out, hold);
  endtask

  initial begin
    logic [319:0] iv, s1, s2, r8;
    int           cyc, dn;

    iv = {64'h80400c0600000000, 128'h000102030405060708090a0b0c0d0e0f,
          128'h000102030405060708090a0b0c0d0e0f};
    r8 = rand320();
    vt[0] = mk(320'd0, 2'b10);
    vt[1] = mk(iv, 2'b00);
    vt[2] = mk(r8, 2'b01);
    vt[3] = mk(iv, 2'b11);
    vt[4] = mk(rand320(), 2'b10);
    vt[5] = mk(rand320(), 2'b00);

    rst_n = 1'b0; start = 1'b0; rounds_sel = 2'b00; state_in = '0;
    #12;
    chk("reset_state", state_out, 320'd0);
    chk("reset_busy", 320'(busy), 320'(0));
    chk("reset_done", 320'(done), 320'(0));
    chk("reset_loop_num", 320'(loop_num), 320'(0));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // First double round of an 8-round run uses constants b4 then a5
    drive_start(r8, 2'b01);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("trace_loop2", state_out, model_rounds(r8, 4, 2));
    cyc = 0;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("trace_final", state_out, vt[2].exp);
    @(posedge clk); #1;

    // start held through the run: mid-run start ignored, done-cycle start accepted
    s1 = rand320(); s2 = rand320();
    drive_start(s1, 2'b10);
    @(posedge clk); #1;
    state_in = s2;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 20);
    chk("b2b_first_cycles", 320'(cyc), 320'(3));
    chk("b2b_first_result", state_out, model_rounds(s1, 6, 6));
    @(posedge clk); #1;
    chk("b2b_relaunch_busy", 320'(busy), 320'(1));
    chk("b2b_relaunch_load", state_out, s2);
    start = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!done && cyc < 20);
    chk("b2b_second_cycles", 320'(cyc), 320'(3));
    chk("b2b_second_result", state_out, model_rounds(s2, 6, 6));
    @(posedge clk); #1;

    // Reset asserted in the second RUN cycle of a 12-round run
    drive_start(iv, 2'b00);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", state_out, 320'd0);
    chk("midrst_busy", 320'(busy), 320'(0));
    chk("midrst_done", 320'(done), 320'(0));
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("midrst_no_done", 320'(dn), 320'(0));
    run_vec(vt[1], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
